// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues operations; the slave side is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bo, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bo, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell with a registered borrow walks the operands;
// the difference bits enter the result register from the MSB side so the
// word is aligned once WIDTH bits have been processed.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic             r_bo;
  logic             r_ovf;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_diff;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic             w_busy;
  logic             w_done;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
    logic diff;
    logic bout;
    diff = x ^ y ^ bi;
    bout = (~x & y) | (~(x ^ y) & bi);
    return {bout, diff};
  endfunction

  assign {w_br_next, w_diff} = fs_cell(r_sa[0], r_sb[0], r_br);
  assign w_res_next          = {w_diff, r_res[WIDTH-1:1]};
  assign w_last              = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Operand capture, serial datapath and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bo    <= 1'b0;
      r_ovf   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
          end
        end
        S_SHIFT: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          // Final bit: publish the result; d/bo/ovf move only here.
          if (w_last) begin
            r_d   <= w_res_next;
            r_bo  <= w_br_next;
            r_ovf <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.d    = r_d;
  assign bus.bo   = r_bo;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {ovf, bo, d} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_sub(input int ua, input int ub, input int ubin);
    int diff;
    int sa;
    int sb;
    int sdiff;
    logic [WIDTH:0] wide;
    logic ovf;
    diff  = ua - ub - ubin;
    wide  = diff[WIDTH:0];
    sa    = (ua >= (1 << (WIDTH-1))) ? ua - (1 << WIDTH) : ua;
    sb    = (ub >= (1 << (WIDTH-1))) ? ub - (1 << WIDTH) : ub;
    sdiff = sa - sb - ubin;
    ovf   = (sdiff > (1 << (WIDTH-1)) - 1) || (sdiff < -(1 << (WIDTH-1)));
    return {ovf, wide};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One framed operation with a bounded wait for done.
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vbin, output logic [WIDTH+1:0] res);
    logic [WIDTH+1:0] exp;
    int nbusy;
    bit got;
    exp       = ref_sub(int'(va), int'(vb), int'(vbin));
    bus.a     = va;
    bus.b     = vb;
    bus.bin   = vbin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = ~va;
    bus.b     = ~vb;
    bus.bin   = ~vbin;
    nbusy = 0;
    got   = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.busy) nbusy++;
      step();
    end
    check_eq("done_seen", 32'(got), 32'd1);
    check_eq("busy_cycles", 32'(nbusy), 32'(WIDTH));
    check_eq("result", 32'({bus.ovf, bus.bo, bus.d}), 32'(exp));
    res = {bus.ovf, bus.bo, bus.d};
    step();
    check_eq("done_pulse_1cyc", 32'(bus.done), 32'd0);
    check_eq("d_hold", 32'({bus.ovf, bus.bo, bus.d}), 32'(exp));
  endtask

  logic [WIDTH+1:0] r;
  logic [7:0] diff_tab;
  logic [7:0] bor_tab;
  logic [2:0] tv;
  logic [WIDTH+1:0] q_exp[$];
  logic [WIDTH+1:0] e;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #2;
    check_eq("reset_outs", 32'({bus.busy, bus.done, bus.ovf, bus.bo, bus.d}), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("idle_outs", 32'({bus.busy, bus.done, bus.ovf, bus.bo, bus.d}), 32'd0);

    // Directed operations from the test plan.
    run_op(8'h35, 8'h12, 1'b0, r);
    check_eq("35-12", 32'(r), {22'd0, 1'b0, 1'b0, 8'h23});
    run_op(8'h12, 8'h35, 1'b0, r);
    check_eq("12-35", 32'(r), {22'd0, 1'b0, 1'b1, 8'hDD});
    run_op(8'h80, 8'h01, 1'b0, r);
    check_eq("80-01", 32'(r), {22'd0, 1'b1, 1'b0, 8'h7F});
    run_op(8'h7F, 8'hFF, 1'b0, r);
    check_eq("7F-FF", 32'(r), {22'd0, 1'b1, 1'b1, 8'h80});
    run_op(8'h00, 8'h00, 1'b1, r);
    check_eq("00-00-1", 32'(r), {22'd0, 1'b0, 1'b1, 8'hFF});
    run_op(8'h5A, 8'h5A, 1'b0, r);
    check_eq("a_eq_b", 32'(r), 32'd0);
    run_op(8'hC3, 8'h00, 1'b0, r);
    check_eq("b_zero", 32'(r), {22'd0, 1'b0, 1'b0, 8'hC3});

    // Full-subtractor truth table on the LSB, indexed by {x, y, bin}.
    diff_tab = 8'b1001_0110;
    bor_tab  = 8'b1000_1110;
    for (int t = 0; t < 8; t++) begin
      tv = 3'(t);
      run_op({7'd0, tv[2]}, {7'd0, tv[1]}, tv[0], r);
      check_eq("tt_diff", 32'(r[0]), 32'(diff_tab[t]));
      check_eq("tt_borrow", 32'(r[WIDTH]), 32'(bor_tab[t]));
    end

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), r);
    end

    // start held high, operands changing every cycle: only IDLE-edge
    // operands count and done recurs every WIDTH+2 cycles.
    bus.start = 1'b1;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.bin   = 1'($urandom);
    for (int k = 0; k < 50; k++) begin
      if (k % (WIDTH + 2) == 0) q_exp.push_back(ref_sub(int'(bus.a), int'(bus.b), int'(bus.bin)));
      step();
      check_eq("held_done", 32'(bus.done), 32'((k % (WIDTH + 2)) == WIDTH));
      if ((k % (WIDTH + 2)) == WIDTH) begin
        e = q_exp.pop_front();
        check_eq("held_result", 32'({bus.ovf, bus.bo, bus.d}), 32'(e));
      end
      bus.a   = WIDTH'($urandom);
      bus.b   = WIDTH'($urandom);
      bus.bin = 1'($urandom);
    end
    bus.start = 1'b0;
    step();

    // Asynchronous reset four cycles into an operation.
    bus.a     = 8'hA5;
    bus.b     = 8'h3C;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    check_eq("rst_async_outs", 32'({bus.busy, bus.done, bus.ovf, bus.bo, bus.d}), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("rst_no_done", 32'({bus.busy, bus.done}), 32'd0);
    end
    run_op(8'h35, 8'h12, 1'b0, r);
    check_eq("post_rst_35-12", 32'(r), {22'd0, 1'b0, 1'b0, 8'h23});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing d = a - b - bin, LSB first, one bit per clock.
- Built on a single full-subtractor cell (difference plus borrow), the inverse of the team's full-adder cell, with a registered borrow.
- Used as a small-area arithmetic unit on the SP605 test designs.
- A start/busy/done handshake frames each operation.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when the result is valid.
- d  output  WIDTH  difference; held from done until the next accepted start.
- bo  output  1  final borrow-out (unsigned a < b + bin); held like d.
- ovf  output  1  signed (two's-complement) overflow; held like d.

Behaviour:
- Reset: the clock is single-domain; rst is asynchronous and active-high. On rst: state=IDLE; busy=0, done=0, d=0, bo=0, ovf=0; all internal shift registers, borrow and bit counter = 0. rst asserted mid-operation aborts it with no partial result or done pulse. After release the block waits in IDLE for a new start.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE -> SHIFT on a rising edge with start=1. a and b load into shift registers sa and sb, bin loads into borrow register br, counter=0, and a[WIDTH-1] and b[WIDTH-1] are saved for ovf.
  - IDLE with start=0: remain in IDLE; outputs hold.
  - SHIFT, each edge:
    - x = sa[0], y = sb[0].
    - diff = x ^ y ^ br.
    - br_next = (~x & y) | (~(x ^ y) & br).
    - sa and sb shift right by 1.
    - diff shifts into the result register from the MSB side (result = {diff, result[WIDTH-1:1]}).
    - counter increments.
  - SHIFT -> DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1). On that same edge, d takes the final result, bo = br_next, and ovf = (a_msb != b_msb) & (d[WIDTH-1] != a_msb).
  - DONE -> IDLE unconditionally on the next edge.
- Latency:
  - Start accepted at edge E0; bits are processed at edges E1..EWIDTH.
  - done is high in the cycle after EWIDTH, i.e. WIDTH cycles after E0 and WIDTH+1 cycles from start to done low.
  - The minimum issue interval is WIDTH+2 cycles.
- Operand handling:
  - start while busy=1 or in DONE is ignored: no restart, no queueing.
  - Changes on a, b or bin after the accepted edge do not affect the operation in progress.
- Output stability:
  - d, bo and ovf change only on the DONE-entry edge and on reset.
  - They hold their previous values during a new operation until its DONE entry.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - {bo, d} equals the (WIDTH+1)-bit two's-complement of a - b - bin.
- Boundary cases:
  - a = b with bin=0 -> d=0, bo=0.
  - bin=1 with a=b -> d = all ones, bo=1.
  - b=0 with bin=0 -> d=a, bo=0, ovf=0.

Test Plan (WIDTH=8):
- 0x35 - 0x12, bin=0, single start pulse:
  - busy high for 8 cycles, then done pulses for 1 cycle.
  - d=0x23, bo=0, ovf=0.
  - d holds after done falls.
- 0x12 - 0x35, bin=0 -> d=0xDD, bo=1, ovf=0.
- 0x80 - 0x01, bin=0 -> d=0x7F, bo=0, ovf=1. Then 0x7F - 0xFF -> d=0x80, bo=1, ovf=1.
- 0x00 - 0x00, bin=1 -> d=0xFF, bo=1, ovf=0. Also sweep all 8 combinations of LSB (a, b, bin) against the full-subtractor truth table.
- start held high continuously with operands changing every cycle:
  - Only the operands present at the IDLE edges are used.
  - done pulses every 10 cycles.
  - Mid-operation operand changes have no effect on d.
- Async reset:
  - rst asserted 4 cycles into an operation -> busy, done, d, bo and ovf read 0 immediately, with no done pulse.
  - A subsequent 0x35 - 0x12 completes correctly (d=0x23).
